// File: rtl/data_mem_responder.sv
// Multi-cycle word memory responder: one request at a time, fixed LATENCY, single-cycle response.
// Optional feature macro: DMEM_BOUNDS_CHECK_EN (flag word indices >= DEPTH instead of aliasing).
module data_mem_responder #(
  parameter int unsigned DEPTH   = 16384,
  parameter int unsigned LATENCY = 4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req_valid,
  input  logic        req_write,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        req_ready,
  output logic        resp_valid,
  output logic [31:0] resp_rdata,
  output logic        resp_err
);

  localparam int unsigned AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CW = (LATENCY > 1) ? $clog2(LATENCY) : 1;
  localparam logic [CW-1:0] CNT_INIT = CW'(LATENCY - 1);

  typedef enum logic [1:0] {IDLE, BUSY, RESP} state_t;

  state_t        state, state_n;
  logic [CW-1:0] cnt;
  logic          wr_q, err_q;
  logic [AW-1:0] idx_q;
  logic [31:0]   wdata_q;
  logic [31:0]   mem [DEPTH];
  logic          accept, finish;
  logic          req_err;
  logic [AW-1:0] req_idx;
  logic          unused_addr;

  assign req_idx     = req_addr[AW+1:2];
  assign unused_addr = ^req_addr;

`ifdef DMEM_BOUNDS_CHECK_EN
  assign req_err = ({2'b00, req_addr[31:2]} >= 32'(DEPTH));
`else
  assign req_err = 1'b0;
`endif

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= state_n;
  end

  always_comb begin
    state_n = state;
    accept  = 1'b0;
    finish  = 1'b0;
    case (state)
      IDLE: if (req_valid) begin
        accept  = 1'b1;
        state_n = BUSY;
      end
      BUSY: if (cnt == '0) begin
        finish  = 1'b1;
        state_n = RESP;
      end
      RESP:    state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end

  assign req_ready = (state == IDLE);

  // Request latch, countdown and registered response; outputs return to 0 outside the response cycle.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt        <= '0;
      wr_q       <= 1'b0;
      err_q      <= 1'b0;
      idx_q      <= '0;
      wdata_q    <= '0;
      resp_valid <= 1'b0;
      resp_rdata <= '0;
      resp_err   <= 1'b0;
    end else begin
      resp_valid <= finish;
      resp_err   <= finish & err_q;
      resp_rdata <= (finish && !wr_q && !err_q) ? mem[idx_q] : '0;
      if (accept) begin
        wr_q    <= req_write;
        err_q   <= req_err;
        idx_q   <= req_idx;
        wdata_q <= req_wdata;
        cnt     <= CNT_INIT;
      end else if (state == BUSY && cnt != '0) begin
        cnt <= cnt - 1'b1;
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int unsigned i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else if (finish && wr_q && !err_q) begin
      mem[idx_q] <= wdata_q;
    end
  end

endmodule

// File: tb/tb_data_mem_responder.sv
// Self-checking bench: two responder instances (LATENCY=4/DEPTH=128 and LATENCY=1/DEPTH=16) against an array model.
module tb_data_mem_responder;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        req_valid  [2];
  logic        req_write  [2];
  logic [31:0] req_addr   [2];
  logic [31:0] req_wdata  [2];
  logic        req_ready  [2];
  logic        resp_valid [2];
  logic [31:0] resp_rdata [2];
  logic        resp_err   [2];

  int checks = 0;
  int errors = 0;

  logic [31:0] m [2][128];

  always #5 clk = ~clk;

  data_mem_responder #(.DEPTH(128), .LATENCY(4)) dut0 (
    .clk(clk), .reset(reset),
    .req_valid(req_valid[0]), .req_write(req_write[0]),
    .req_addr(req_addr[0]), .req_wdata(req_wdata[0]),
    .req_ready(req_ready[0]), .resp_valid(resp_valid[0]),
    .resp_rdata(resp_rdata[0]), .resp_err(resp_err[0])
  );

  data_mem_responder #(.DEPTH(16), .LATENCY(1)) dut1 (
    .clk(clk), .reset(reset),
    .req_valid(req_valid[1]), .req_write(req_write[1]),
    .req_addr(req_addr[1]), .req_wdata(req_wdata[1]),
    .req_ready(req_ready[1]), .resp_valid(resp_valid[1]),
    .resp_rdata(resp_rdata[1]), .resp_err(resp_err[1])
  );

  function automatic int unsigned depth_of(input int u);
    return (u == 0) ? 128 : 16;
  endfunction

  function automatic int latency_of(input int u);
    return (u == 0) ? 4 : 1;
  endfunction

  task automatic model_clear();
    for (int u = 0; u < 2; u++)
      for (int i = 0; i < 128; i++) m[u][i] = '0;
  endtask

  task automatic model_req(input int u, input bit w, input logic [31:0] a, input logic [31:0] d,
                           output logic [31:0] rd, output logic er);
    int unsigned idx;
    idx = a >> 2;
    rd  = '0;
    er  = 1'b0;
`ifdef DMEM_BOUNDS_CHECK_EN
    if (idx >= depth_of(u)) begin
      er = 1'b1;
      return;
    end
`else
    idx = idx % depth_of(u);
`endif
    if (w) m[u][idx] = d;
    else   rd = m[u][idx];
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset = 1'b1;
    repeat (3) @(negedge clk);
    reset = 1'b0;
    model_clear();
  endtask

  // One transaction; checks req_ready stays low until the response and returns one cycle later.
  task automatic xact(input int u, input bit w, input logic [31:0] a, input logic [31:0] d, input bit scramble,
                      output logic [31:0] rd, output logic er, output int lat);
    int n;
    n = 0;
    @(negedge clk);
    while (!req_ready[u] && n < 20) begin
      @(negedge clk);
      n++;
    end
    checks++;
    if (req_ready[u] !== 1'b1) begin
      errors++;
      $display("FAIL ready_wait u%0d: req_ready=%b required 1", u, req_ready[u]);
    end
    req_valid[u] = 1'b1;
    req_write[u] = w;
    req_addr[u]  = a;
    req_wdata[u] = d;
    @(posedge clk);
    #1;
    if (scramble) begin
      req_addr[u]  = a + 32'd4;
      req_wdata[u] = ~d;
      req_write[u] = 1'b1;
    end else begin
      req_valid[u] = 1'b0;
    end
    lat = -1;
    rd  = '0;
    er  = 1'b0;
    for (int i = 1; i <= 20; i++) begin
      @(negedge clk);
      checks++;
      if (req_ready[u] !== 1'b0) begin
        errors++;
        $display("FAIL ready_busy u%0d: req_ready=%b required 0 at cycle %0d", u, req_ready[u], i);
      end
      if (resp_valid[u]) begin
        lat = i - 1;
        rd  = resp_rdata[u];
        er  = resp_err[u];
        break;
      end
    end
    req_valid[u] = 1'b0;
    if (lat < 0) begin
      checks++;
      errors++;
      $display("FAIL resp_timeout u%0d: no resp_valid within 20 cycles", u);
    end
    @(negedge clk);
    checks++;
    if (req_ready[u] !== 1'b1 || resp_valid[u] !== 1'b0) begin
      errors++;
      $display("FAIL after_resp u%0d: req_ready=%b resp_valid=%b required 1/0", u, req_ready[u], resp_valid[u]);
    end
  endtask

  task automatic run(input int u, input bit w, input logic [31:0] a, input logic [31:0] d, input bit scramble,
                     input string name);
    logic [31:0] erd, rd;
    logic        eer, er;
    int          lat;
    model_req(u, w, a, d, erd, eer);
    xact(u, w, a, d, scramble, rd, er, lat);
    checks++;
    if (lat != latency_of(u)) begin
      errors++;
      $display("FAIL %s latency: got %0d required %0d", name, lat, latency_of(u));
    end
    checks++;
    if (rd !== erd) begin
      errors++;
      $display("FAIL %s rdata: got %h required %h (addr %h)", name, rd, erd, a);
    end
    checks++;
    if (er !== eer) begin
      errors++;
      $display("FAIL %s err: got %b required %b (addr %h)", name, er, eer, a);
    end
  endtask

  task automatic test_reset();
    do_reset();
    for (int u = 0; u < 2; u++) begin
      checks++;
      if (req_ready[u] !== 1'b1 || resp_valid[u] !== 1'b0 || resp_rdata[u] !== 32'h0 || resp_err[u] !== 1'b0) begin
        errors++;
        $display("FAIL reset_state u%0d: ready=%b valid=%b rdata=%h err=%b required 1/0/0/0",
                 u, req_ready[u], resp_valid[u], resp_rdata[u], resp_err[u]);
      end
    end
  endtask

  task automatic test_store_load();
    run(0, 1'b1, 32'h100, 32'hDEADBEEF, 1'b0, "store_0x100");
    run(0, 1'b0, 32'h100, 32'h0, 1'b0, "load_0x100");
  endtask

  task automatic test_stability();
    run(0, 1'b1, 32'h20, 32'h11, 1'b1, "stab_store");
    run(0, 1'b0, 32'h20, 32'h0, 1'b0, "stab_load_20");
    run(0, 1'b0, 32'h24, 32'h0, 1'b0, "stab_load_24");
  endtask

  task automatic test_min_latency();
    run(1, 1'b0, 32'h8, 32'h0, 1'b0, "minlat_load");
  endtask

  task automatic test_out_of_range();
    run(1, 1'b1, 32'h40, 32'hAA, 1'b0, "oor_store");
    run(1, 1'b0, 32'h0, 32'h0, 1'b0, "oor_load_0");
  endtask

  task automatic test_handshake();
    int acc [$];
    do_reset();
    @(negedge clk);
    req_valid[0] = 1'b1;
    req_write[0] = 1'b0;
    req_addr[0]  = 32'h0;
    req_wdata[0] = $urandom;
    for (int c = 0; c < 30; c++) begin
      if (req_ready[0]) acc.push_back(c);
      if (resp_valid[0]) begin
        checks++;
        if (resp_rdata[0] !== 32'h0 || resp_err[0] !== 1'b0) begin
          errors++;
          $display("FAIL hs_resp: rdata=%h err=%b required 0/0", resp_rdata[0], resp_err[0]);
        end
      end
      @(negedge clk);
    end
    req_valid[0] = 1'b0;
    checks++;
    if (acc.size() < 4) begin
      errors++;
      $display("FAIL hs_count: got %0d acceptances required at least 4", acc.size());
    end
    for (int i = 1; i < acc.size(); i++) begin
      checks++;
      if (acc[i] - acc[i-1] != 6) begin
        errors++;
        $display("FAIL hs_spacing: got %0d edges required 6", acc[i] - acc[i-1]);
      end
    end
    repeat (8) @(negedge clk);
  endtask

  task automatic test_reset_mid();
    @(negedge clk);
    req_valid[0] = 1'b1;
    req_write[0] = 1'b1;
    req_addr[0]  = 32'h40;
    req_wdata[0] = 32'h55;
    @(posedge clk);
    #1;
    req_valid[0] = 1'b0;
    @(posedge clk);
    @(posedge clk);
    #2;
    reset = 1'b1;
    repeat (3) begin
      @(negedge clk);
      checks++;
      if (resp_valid[0] !== 1'b0) begin
        errors++;
        $display("FAIL rstmid_valid_in_reset: resp_valid=%b required 0", resp_valid[0]);
      end
    end
    reset = 1'b0;
    model_clear();
    repeat (8) begin
      @(negedge clk);
      checks++;
      if (resp_valid[0] !== 1'b0 || req_ready[0] !== 1'b1) begin
        errors++;
        $display("FAIL rstmid_after: resp_valid=%b req_ready=%b required 0/1", resp_valid[0], req_ready[0]);
      end
    end
    run(0, 1'b0, 32'h40, 32'h0, 1'b0, "rstmid_load_40");
  endtask

  task automatic test_random();
    for (int k = 0; k < 40; k++) begin
      int          u;
      bit          w;
      int unsigned word;
      logic [31:0] a;
      u    = k % 2;
      w    = $urandom_range(0, 1);
      word = $urandom_range(0, 7);
      if ($urandom_range(0, 3) == 0) word = word + depth_of(u);
      a    = (word << 2) | $urandom_range(0, 3);
      run(u, w, a, $urandom, ($urandom_range(0, 3) == 0), "random");
    end
  endtask

  initial begin
    for (int u = 0; u < 2; u++) begin
      req_valid[u] = 1'b0;
      req_write[u] = 1'b0;
      req_addr[u]  = '0;
      req_wdata[u] = '0;
    end
    model_clear();
    test_reset();
    test_store_load();
    test_stability();
    test_min_latency();
    test_out_of_range();
    test_handshake();
    test_reset_mid();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout: simulation did not complete");
    $fatal(1);
  end

endmodule
